// File: rtl/vm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vm_pkg: shared coin encodings, coin values and purchase-path FSM states.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package vm_pkg;

    localparam int MONEY_W = 7;

    localparam logic [1:0] COIN_1  = 2'b00;
    localparam logic [1:0] COIN_2  = 2'b01;
    localparam logic [1:0] COIN_5  = 2'b10;
    localparam logic [1:0] COIN_10 = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PRESENT = 2'd2,
        REFUND  = 2'd3
    } state_t;

    function automatic logic [MONEY_W-1:0] coin_value(input logic [1:0] code);
        logic [MONEY_W-1:0] val;
        case (code)
            COIN_1:  val = 7'd1;
            COIN_2:  val = 7'd2;
            COIN_5:  val = 7'd5;
            default: val = 7'd10;
        endcase
        return val;
    endfunction

endpackage
`default_nettype wire

// File: rtl/coin_denom_sel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | coin_denom_sel: picks the largest coin not exceeding the remaining amount. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module coin_denom_sel
    import vm_pkg::*;
(
    input  logic [MONEY_W-1:0] remaining,
    output logic [1:0]         chg_type,
    output logic [MONEY_W-1:0] coin_val
);

    always_comb begin
        chg_type = COIN_1;
        coin_val = '0;
        if (remaining >= 7'd10) begin
            chg_type = COIN_10;
            coin_val = 7'd10;
        end else if (remaining >= 7'd5) begin
            chg_type = COIN_5;
            coin_val = 7'd5;
        end else if (remaining >= 7'd2) begin
            chg_type = COIN_2;
            coin_val = 7'd2;
        end else if (remaining == 7'd1) begin
            chg_type = COIN_1;
            coin_val = 7'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/coin_collector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | coin_collector: accumulates coin credit, presents it, dispenses change.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module coin_collector
    import vm_pkg::*;
#(
    parameter int MAX_CREDIT     = 127,
    parameter int TIMEOUT_CYCLES = 200,
    parameter int TMR_W          = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       coin_valid,
    input  logic [1:0] coin_type,
    input  logic       confirm,
    input  logic       cancel,
    output logic       money_valid,
    output logic [6:0] money,
    input  logic       done,
    input  logic [6:0] change_in,
    output logic       coin_reject,
    output logic       chg_valid,
    output logic [1:0] chg_type,
    output logic       busy
);

    localparam logic [MONEY_W:0] MAX_CREDIT_W = (MONEY_W+1)'(MAX_CREDIT);
    localparam logic [TMR_W-1:0] TMR_LAST     = TMR_W'(TIMEOUT_CYCLES - 1);

    state_t             state_q, state_d;
    logic [MONEY_W-1:0] credit_q, credit_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [MONEY_W-1:0] refund_q, refund_d;
    logic [MONEY_W-1:0] money_q, money_d;
    logic               money_valid_q, money_valid_d;
    logic               coin_reject_q, coin_reject_d;
    logic               chg_valid_q, chg_valid_d;
    logic [1:0]         chg_type_q, chg_type_d;
    logic               busy_q, busy_d;

    logic [MONEY_W-1:0] in_val;
    logic [MONEY_W:0]   sum;
    logic               fits;
    logic [MONEY_W-1:0] clamp;
    logic [1:0]         sel_type;
    logic [MONEY_W-1:0] sel_val;

    coin_denom_sel u_denom_sel (
        .remaining (refund_q),
        .chg_type  (sel_type),
        .coin_val  (sel_val)
    );

    always_comb begin
        in_val = coin_value(coin_type);
        // Widened add so an overflowing coin is detected instead of wrapping.
        sum    = {1'b0, credit_q} + {1'b0, in_val};
        fits   = (sum <= MAX_CREDIT_W);
        clamp  = (change_in < credit_q) ? change_in : credit_q;

        state_d       = state_q;
        credit_d      = credit_q;
        timer_d       = timer_q;
        refund_d      = refund_q;
        coin_reject_d = 1'b0;
        chg_valid_d   = 1'b0;
        chg_type_d    = 2'b00;

        case (state_q)
            IDLE: begin
                if (coin_valid) begin
                    credit_d = in_val;
                    timer_d  = '0;
                    state_d  = COLLECT;
                end
            end
            COLLECT: begin
                if (cancel) begin
                    coin_reject_d = coin_valid;
                    refund_d      = credit_q;
                    timer_d       = '0;
                    state_d       = REFUND;
                end else begin
                    if (coin_valid && fits) begin
                        credit_d = sum[MONEY_W-1:0];
                        timer_d  = '0;
                    end else begin
                        coin_reject_d = coin_valid;
                        timer_d       = timer_q + 1'b1;
                    end
                    if (confirm) begin
                        timer_d = '0;
                        state_d = PRESENT;
                    end else if (!(coin_valid && fits) && timer_q == TMR_LAST) begin
                        refund_d = credit_q;
                        timer_d  = '0;
                        state_d  = REFUND;
                    end
                end
            end
            PRESENT: begin
                coin_reject_d = coin_valid;
                if (done) begin
                    refund_d = clamp;
                    if (clamp == '0) begin
                        credit_d = '0;
                        state_d  = IDLE;
                    end else begin
                        state_d  = REFUND;
                    end
                end
            end
            REFUND: begin
                coin_reject_d = coin_valid;
                chg_valid_d   = 1'b1;
                chg_type_d    = sel_type;
                refund_d      = refund_q - sel_val;
                if (refund_d == '0) begin
                    credit_d = '0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        money_d       = credit_d;
        money_valid_d = (state_d == PRESENT);
        busy_d        = (state_d == PRESENT) || (state_d == REFUND);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            credit_q      <= '0;
            timer_q       <= '0;
            refund_q      <= '0;
            money_q       <= '0;
            money_valid_q <= 1'b0;
            coin_reject_q <= 1'b0;
            chg_valid_q   <= 1'b0;
            chg_type_q    <= 2'b00;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            timer_q       <= timer_d;
            refund_q      <= refund_d;
            money_q       <= money_d;
            money_valid_q <= money_valid_d;
            coin_reject_q <= coin_reject_d;
            chg_valid_q   <= chg_valid_d;
            chg_type_q    <= chg_type_d;
            busy_q        <= busy_d;
        end
    end

    assign money       = money_q;
    assign money_valid = money_valid_q;
    assign coin_reject = coin_reject_q;
    assign chg_valid   = chg_valid_q;
    assign chg_type    = chg_type_q;
    assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_coin_collector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_coin_collector: directed self-checking bench for coin_collector.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_coin_collector;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_type = 2'b00;
    logic       confirm = 1'b0;
    logic       cancel = 1'b0;
    logic       money_valid;
    logic [6:0] money;
    logic       done = 1'b0;
    logic [6:0] change_in = 7'd0;
    logic       coin_reject;
    logic       chg_valid;
    logic [1:0] chg_type;
    logic       busy;

    int compared = 0;
    int mismatched = 0;

    coin_collector #(
        .MAX_CREDIT     (127),
        .TIMEOUT_CYCLES (200),
        .TMR_W          (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .coin_valid  (coin_valid),
        .coin_type   (coin_type),
        .confirm     (confirm),
        .cancel      (cancel),
        .money_valid (money_valid),
        .money       (money),
        .done        (done),
        .change_in   (change_in),
        .coin_reject (coin_reject),
        .chg_valid   (chg_valid),
        .chg_type    (chg_type),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Packs {money_valid, money, coin_reject, chg_valid, chg_type, busy} for one-shot checks.
    function automatic logic [31:0] outs();
        return {19'd0, money_valid, money, coin_reject, chg_valid, chg_type, busy};
    endfunction

    function automatic logic [31:0] pk(input logic mv, input logic [6:0] m, input logic cr,
                                       input logic cv, input logic [1:0] ct, input logic b);
        return {19'd0, mv, m, cr, cv, ct, b};
    endfunction

    task automatic coin(input logic [1:0] t);
        coin_valid = 1'b1;
        coin_type  = t;
        tick();
        coin_valid = 1'b0;
    endtask

    initial begin
        // Reset
        tick(); tick();
        chk("reset_outputs", outs(), pk(0, 0, 0, 0, 2'b00, 0));
        rst = 1'b0;

        // 10 + 10, confirm, change 16 -> 10, 5, 1
        coin(2'b11);
        chk("first_coin", outs(), pk(0, 10, 0, 0, 2'b00, 0));
        coin(2'b11);
        chk("second_coin", outs(), pk(0, 20, 0, 0, 2'b00, 0));
        confirm = 1'b1; tick(); confirm = 1'b0;
        chk("present_20", outs(), pk(1, 20, 0, 0, 2'b00, 1));
        coin(2'b00);
        chk("present_coin_rej", outs(), pk(1, 20, 1, 0, 2'b00, 1));
        done = 1'b1; change_in = 7'd16; tick(); done = 1'b0; change_in = 7'd0;
        chk("done_to_refund", outs(), pk(0, 20, 0, 0, 2'b00, 1));
        tick();
        chk("chg16_a_10", outs(), pk(0, 20, 0, 1, 2'b11, 1));
        tick();
        chk("chg16_b_5", outs(), pk(0, 20, 0, 1, 2'b10, 1));
        tick();
        chk("chg16_c_1", outs(), pk(0, 0, 0, 1, 2'b00, 0));
        tick();
        chk("chg16_idle", outs(), pk(0, 0, 0, 0, 2'b00, 0));

        // Overflow rejection at 120 + 10, then 120 + 5
        for (int i = 0; i < 12; i++) coin(2'b11);
        chk("credit_120", {25'd0, money}, 32'd120);
        coin(2'b11);
        chk("overflow_reject", outs(), pk(0, 120, 1, 0, 2'b00, 0));
        tick();
        chk("reject_one_cycle", {31'd0, coin_reject}, 32'd0);
        coin(2'b10);
        chk("credit_125", outs(), pk(0, 125, 0, 0, 2'b00, 0));

        // Cancel 125, reset during refund
        cancel = 1'b1; tick(); cancel = 1'b0;
        chk("cancel_125", outs(), pk(0, 125, 0, 0, 2'b00, 1));
        tick();
        chk("refund125_first", outs(), pk(0, 125, 0, 1, 2'b11, 1));
        rst = 1'b1; tick(); rst = 1'b0;
        chk("mid_refund_reset", outs(), pk(0, 0, 0, 0, 2'b00, 0));
        tick();
        chk("post_reset_quiet", outs(), pk(0, 0, 0, 0, 2'b00, 0));

        // Credit 7, cancel with a coin -> reject, refund 5, 2
        coin(2'b10);
        coin(2'b01);
        chk("credit_7", {25'd0, money}, 32'd7);
        cancel = 1'b1; coin_valid = 1'b1; coin_type = 2'b00; tick();
        cancel = 1'b0; coin_valid = 1'b0;
        chk("cancel_with_coin", outs(), pk(0, 7, 1, 0, 2'b00, 1));
        tick();
        chk("refund7_5", outs(), pk(0, 7, 0, 1, 2'b10, 1));
        tick();
        chk("refund7_2", outs(), pk(0, 0, 0, 1, 2'b01, 0));
        tick();
        chk("refund7_idle", outs(), pk(0, 0, 0, 0, 2'b00, 0));

        // Inactivity timeout with a single 2
        coin(2'b01);
        repeat (199) tick();
        chk("timeout_not_yet", outs(), pk(0, 2, 0, 0, 2'b00, 0));
        tick();
        chk("timeout_refund", outs(), pk(0, 2, 0, 0, 2'b00, 1));
        tick();
        chk("timeout_coin_2", outs(), pk(0, 0, 0, 1, 2'b01, 0));
        tick();
        chk("timeout_idle", outs(), pk(0, 0, 0, 0, 2'b00, 0));

        // PRESENT with 20, change 0 -> straight to IDLE
        coin(2'b11); coin(2'b11);
        confirm = 1'b1; tick(); confirm = 1'b0;
        done = 1'b1; change_in = 7'd0; tick(); done = 1'b0;
        chk("zero_change_idle", outs(), pk(0, 0, 0, 0, 2'b00, 0));
        tick();
        chk("zero_change_no_chg", outs(), pk(0, 0, 0, 0, 2'b00, 0));

        // PRESENT with 20, change 30 clamped -> 10, 10
        coin(2'b11); coin(2'b11);
        confirm = 1'b1; tick(); confirm = 1'b0;
        done = 1'b1; change_in = 7'd30; tick(); done = 1'b0; change_in = 7'd0;
        tick();
        chk("clamp_10_a", outs(), pk(0, 20, 0, 1, 2'b11, 1));
        tick();
        chk("clamp_10_b", outs(), pk(0, 0, 0, 1, 2'b11, 0));
        tick();
        chk("clamp_idle", outs(), pk(0, 0, 0, 0, 2'b00, 0));

        // Confirm together with a coin presents the updated credit
        coin(2'b10);
        confirm = 1'b1; coin_valid = 1'b1; coin_type = 2'b01; tick();
        confirm = 1'b0; coin_valid = 1'b0;
        chk("confirm_with_coin", outs(), pk(1, 7, 0, 0, 2'b00, 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
